hs_stream_gen: RTL
==================

# hs_stream_gen

Command-driven valid/ready stream transmitter that sits at the producing end of a valid/ready link feeding our 2-entry handshake buffers. A single command selects a packet length, seed, data pattern and inter-word gap. The block emits that many words on the downstream port with `down_last` on the final word, obeys backpressure, and pulses `done_pulse` on completion. It is used as the on-chip traffic source for link bring-up and buffer throughput checks.

## Interface
- `WORD_WIDTH`, 32, data word width.
- `LEN_WIDTH`, 16, width of the packet length field.
- `GAP_WIDTH`, 4, width of the idle-gap field.
- `clk`  in  1  clock, all logic rising-edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when high together with `cmd_valid`.
- `cmd_len`  in  LEN_WIDTH  words in the packet; 0 is legal.
- `cmd_seed`  in  WORD_WIDTH  first data word.
- `cmd_mode`  in  1  data pattern: 0 = incrementing, 1 = LFSR.
- `cmd_gap`  in  GAP_WIDTH  idle cycles inserted after each accepted non-last word.
- `down_valid`  out  1  word offered.
- `down_data`  out  WORD_WIDTH  word.
- `down_last`  out  1  final word of the packet.
- `down_ready`  in  1  consumer accepts.
- `busy`  out  1  packet in progress (state ≠ IDLE).
- `done_pulse`  out  1  one-cycle completion strobe.

## Operation
- FSM states:
  - IDLE: `cmd_ready=1`.
  - SEND: `down_valid=1`.
  - GAP: `down_valid=0`, counting down the gap.
- `cmd_ready` = (state==IDLE), combinational. All other outputs are registered.
- Command accept (`cmd_valid & cmd_ready`, rst_n high):
  - Latch len into `remaining`, seed into `cur`, plus mode and gap.
  - In LFSR mode, a seed of 0 is replaced by 1 to avoid lock-up.
  - len==0: stay IDLE and assert `done_pulse` next cycle; no beats are emitted.
  - len>0: go to SEND.
- In SEND:
  - `down_data = cur`.
  - `down_last = (remaining==1)`.
- Handshake (`down_valid & down_ready`):
  - `remaining` decrements and `cur` advances.
  - Last word: go to IDLE and set `done_pulse` for one cycle.
  - Otherwise, gap≠0: go to GAP with the counter loaded to gap, then return to SEND when the counter reaches 1→0 (exactly gap idle cycles). Gap==0: remain in SEND.
- Without a handshake, `down_data`, `down_last` and `down_valid` hold stable. `down_valid` never falls before acceptance.
- Pattern advance:
  - Incrementing: `cur+1` mod 2^WORD_WIDTH (wraps from all-ones to 0).
  - LFSR: `{cur[W-2:0], ^(cur & LFSR_TAPS)}`, with `LFSR_TAPS` = 32'h8020_0003 for W=32.
- Commands arriving while busy are not accepted; the producer holds them.
- Reset mid-packet:
  - Next edge forces IDLE and drops `down_valid`/`down_last`.
  - No `done_pulse`; the packet is aborted. Dropping valid is permitted only on reset.

## Timing
- Reset values:
  - `down_valid=0`, `down_last=0`, `down_data=0`, `busy=0`, `done_pulse=0`.
  - `cmd_ready=1` once state is IDLE. Commands are ignored while `rst_n` is low.
- Accept at edge T: first `down_valid` is high from T+1.
- Throughput with `down_ready` held high: 1 word/cycle at gap 0; 1 word per gap+1 cycles otherwise.
- `done_pulse` is high in the cycle after the last handshake. `cmd_ready` is high in that same cycle.
- Back-to-back packets: the next first word appears 2 cycles after the previous last handshake.
- len==0: `done_pulse` at T+1; `busy` stays 0.

## Structure
- Package `hs_gen_pkg`:
  - State enum (IDLE/SEND/GAP).
  - Mode encodings `MODE_INC`, `MODE_LFSR`.
  - `LFSR_TAPS` constant per supported width.
- Sub-module `hs_pattern_next`: combinational next-word function (mode, cur → next). It is shared with the matching stream checker.

## Test plan
- Incrementing run: reset, then cmd len=4, seed=0x10, inc, gap=0, ready=1 → data 0x10, 0x11, 0x12, 0x13 on 4 consecutive cycles; last on 0x13; `done_pulse` on the next cycle; `busy` falls with it.
- Backpressure and wrap: len=3, seed=0xFFFF_FFFF, inc; ready low for 2 cycles, then alternating → valid never drops; data held while ready is low; accepted sequence is 0xFFFF_FFFF, 0x0, 0x1.
- LFSR: len=3, seed=0x0000_0000, mode=1 → 0x1, 0x3, 0x6. Seed 0x1 gives the same sequence.
- Gap: len=3, gap=2, ready=1 → `down_valid` pattern 1,0,0,1,0,0,1; last only on the third beat.
- Zero length: cmd len=0 → no `down_valid`; `done_pulse` one cycle after accept; `cmd_ready` stays 1.
- Reset abort: len=5, reset after 2 accepted words → `down_valid` 0 after the reset edge; no `done_pulse`; a new cmd len=1 seed=0xA5 emits 0xA5 with last set.

Source files
------------

// File: rtl/hs_stream_gen_pkg.sv
// Shared types and constants for the stream generator and its checker.
// No logic; pure declarations.
// Not applicable: no flow control here.
package hs_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic MODE_INC  = 1'b0;
    localparam logic MODE_LFSR = 1'b1;

    // Maximal-length Fibonacci taps: new bit = parity(cur & taps), shifted in at bit 0.
    localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
    localparam logic [15:0] LFSR_TAPS_16 = 16'hD008;
    localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;
    localparam logic [63:0] LFSR_TAPS_64 = 64'hD800_0000_0000_0000;

    function automatic logic [63:0] lfsr_taps(input int width);
        logic [63:0] taps;
        case (width)
            8:       taps = 64'(LFSR_TAPS_8);
            16:      taps = 64'(LFSR_TAPS_16);
            32:      taps = 64'(LFSR_TAPS_32);
            64:      taps = LFSR_TAPS_64;
            default: taps = 64'(LFSR_TAPS_32);
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/hs_stream_gen_if.sv
// Command and downstream valid/ready bundle of the stream generator.
// Wires only; zero latency.
// Handshake semantics are owned by the endpoints.
interface hs_stream_gen_if #(
    parameter int WORD_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int GAP_WIDTH  = 4
) ();
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic [WORD_WIDTH-1:0] cmd_seed;
    logic                  cmd_mode;
    logic [GAP_WIDTH-1:0]  cmd_gap;

    logic                  down_valid;
    logic [WORD_WIDTH-1:0] down_data;
    logic                  down_last;
    logic                  down_ready;

    // Generator side.
    modport master (
        input  cmd_valid, cmd_len, cmd_seed, cmd_mode, cmd_gap, down_ready,
        output cmd_ready, down_valid, down_data, down_last
    );

    // Command producer / downstream consumer side.
    modport slave (
        output cmd_valid, cmd_len, cmd_seed, cmd_mode, cmd_gap, down_ready,
        input  cmd_ready, down_valid, down_data, down_last
    );
endinterface

// File: rtl/hs_stream_gen_pattern.sv
// Next data word for the incrementing or LFSR pattern.
// Combinational, zero latency.
// No flow control; caller decides when to advance.
module hs_pattern_next
    import hs_gen_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         mode,
    input  logic [W-1:0] cur,
    output logic [W-1:0] nxt
);
    localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

    always_comb begin
        if (mode == MODE_LFSR) begin
            nxt = {cur[W-2:0], ^(cur & TAPS)};
        end else begin
            nxt = cur + W'(1);
        end
    end
endmodule

// File: rtl/hs_stream_gen.sv
// Command-driven packet source on a valid/ready link (inc or LFSR data, optional gaps).
// First word valid one cycle after command accept; done_pulse one cycle after last beat.
// Holds data/last/valid stable under down_ready low; refuses commands while busy.
module hs_stream_gen
    import hs_gen_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int GAP_WIDTH  = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    hs_stream_gen_if.master bus,
    output logic           busy,
    output logic           done_pulse
);
    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic [WORD_WIDTH-1:0] cur_q, cur_d, cur_nxt, seed_fix;
    logic                  mode_q, mode_d;
    logic [GAP_WIDTH-1:0]  gap_q, gap_d, gap_cnt_q, gap_cnt_d;
    logic                  done_d, last_d;
    logic                  valid_q, last_q, busy_q, done_q;
    logic                  accept, beat;

    assign bus.cmd_ready  = (state_q == IDLE);
    assign bus.down_valid = valid_q;
    assign bus.down_last  = last_q;
    assign bus.down_data  = cur_q;
    assign busy           = busy_q;
    assign done_pulse     = done_q;

    assign accept = bus.cmd_valid && bus.cmd_ready;
    assign beat   = valid_q && bus.down_ready;

    // An all-zero LFSR state never leaves zero.
    assign seed_fix = (bus.cmd_mode == MODE_LFSR && bus.cmd_seed == '0)
                      ? WORD_WIDTH'(1) : bus.cmd_seed;

    hs_pattern_next #(.W(WORD_WIDTH)) u_next (
        .mode (mode_q),
        .cur  (cur_q),
        .nxt  (cur_nxt)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        cur_d       = cur_q;
        mode_d      = mode_q;
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    remaining_d = bus.cmd_len;
                    cur_d       = seed_fix;
                    mode_d      = bus.cmd_mode;
                    gap_d       = bus.cmd_gap;
                    if (bus.cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (beat) begin
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    cur_d       = cur_nxt;
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (gap_q != '0) begin
                        state_d   = GAP;
                        gap_cnt_d = gap_q;
                    end
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
                if (gap_cnt_q <= GAP_WIDTH'(1)) begin
                    state_d = SEND;
                end
            end
            default: state_d = IDLE;
        endcase
        last_d = (state_d == SEND) && (remaining_d == LEN_WIDTH'(1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            cur_q       <= '0;
            mode_q      <= MODE_INC;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            cur_q       <= cur_d;
            mode_q      <= mode_d;
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
            valid_q     <= (state_d == SEND);
            last_q      <= last_d;
            busy_q      <= (state_d != IDLE);
            done_q      <= done_d;
        end
    end
endmodule
